// File: rtl/mult_div_unit_pkg.sv
// Shared MD op codes, FSM encoding and the combinational multiply/divide datapath.
// The hazard unit and EX result mux import the same op constants.
package mult_div_unit_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;
    localparam logic [2:0] MD_RSVD  = 3'd7;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam int CNT_W           = 16;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_result_t;

    // Signed divide runs on magnitudes so INT_MIN / -1 wraps to INT_MIN instead of trapping.
    function automatic md_result_t md_compute(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        md_result_t  res;
        logic [63:0] prod;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] quo;
        logic [31:0] rem;
        logic        neg_a;
        logic        neg_b;
        res   = '0;
        prod  = '0;
        neg_a = (op == MD_DIV) && a[31];
        neg_b = (op == MD_DIV) && b[31];
        mag_a = neg_a ? (~a + 32'd1) : a;
        mag_b = neg_b ? (~b + 32'd1) : b;
        quo   = '0;
        rem   = '0;
        if (mag_b != 32'd0) begin
            quo = mag_a / mag_b;
            rem = mag_a % mag_b;
        end
        case (op)
            MD_MULT: begin
                prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                res  = {prod[63:32], prod[31:0]};
            end
            MD_MULTU: begin
                prod = {32'd0, a} * {32'd0, b};
                res  = {prod[63:32], prod[31:0]};
            end
            MD_DIV: begin
                res.lo = (neg_a ^ neg_b) ? (~quo + 32'd1) : quo;
                res.hi = neg_a ? (~rem + 32'd1) : rem;
            end
            MD_DIVU: begin
                res.lo = quo;
                res.hi = rem;
            end
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit holding HI/LO; models latency with a Busy down-counter.
//   state | meaning
//   IDLE  | accepting Start; MTHI/MTLO write immediately
//   RUN   | result pending, counting down to commit
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    logic             r_state;
    logic [CNT_W-1:0] r_cnt;
    md_result_t       r_pend;
    logic             r_div0;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    md_result_t w_result;
    logic       w_is_mul;
    logic       w_is_div;

    assign w_result = md_compute(MDOp, A, B);
    assign w_is_mul = (MDOp == MD_MULT) || (MDOp == MD_MULTU);
    assign w_is_div = (MDOp == MD_DIV)  || (MDOp == MD_DIVU);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_div0  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        if (w_is_mul || w_is_div) begin
                            r_pend  <= w_result;
                            r_div0  <= w_is_div && (B == 32'd0);
                            r_cnt   <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                            r_state <= ST_RUN;
                        end else if (MDOp == MD_MTHI) begin
                            r_hi <= A;
                        end else if (MDOp == MD_MTLO) begin
                            r_lo <= A;
                        end
                    end
                end
                default: begin
                    // Start is ignored here; the hazard unit is responsible for holding it off.
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                        if (!r_div0) begin
                            r_hi <= r_pend.hi;
                            r_lo <= r_pend.lo;
                        end
                    end
                end
            endcase
        end
    end

    assign Busy = (r_state == ST_RUN);
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus randomized checks of mult_div_unit against an arithmetic HI/LO model.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .MDOp  (MDOp),
        .Start (Start),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural definitions.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] hi, output logic [31:0] lo, output int cycles);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        hi = m_hi;
        lo = m_lo;
        cycles = 0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; cycles = MC; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; cycles = MC; end
            3'd3: begin
                cycles = DC;
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    p = 64'(q); lo = p[31:0];
                    p = 64'(r); hi = p[31:0];
                end
            end
            3'd4: begin
                cycles = DC;
                if (b != 0) begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            3'd5: hi = a;
            3'd6: lo = a;
            default: ;
        endcase
    endtask

    // Entered and left on a negedge; the caller may issue the next op at once (back-to-back).
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit poke);
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        int          e_cyc;
        int          cnt;
        model_op(op, a, b, e_hi, e_lo, e_cyc);
        Start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        @(negedge clk);
        Start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        cnt   = 0;
        while (Busy && cnt < 200) begin
            cnt++;
            if (cnt == 1) begin
                check_val({tag, "_hold_hi"}, HI, m_hi);
                check_val({tag, "_hold_lo"}, LO, m_lo);
            end
            if (poke && cnt == 2) begin
                Start = 1'b1;
                MDOp  = MD_MTHI;
                A     = 32'hBAD0_BAD0;
            end else if (poke && cnt == 3) begin
                Start = 1'b0;
            end
            @(negedge clk);
        end
        Start = 1'b0;
        check_val({tag, "_busy_cycles"}, 64'(cnt), 64'(e_cyc));
        check_val({tag, "_hi"}, HI, e_hi);
        check_val({tag, "_lo"}, LO, e_lo);
        m_hi = e_hi;
        m_lo = e_lo;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b1;
        Start = 1'b0;
        MDOp  = MD_NONE;
        A     = '0;
        B     = '0;
        m_hi  = '0;
        m_lo  = '0;
        repeat (2) @(negedge clk);
        check_val("rst_busy", 64'(Busy), 64'd0);
        check_val("rst_hi", HI, 32'd0);
        check_val("rst_lo", LO, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Reset mid-operation aborts the pending commit.
        do_op("pre_mthi", MD_MTHI, 32'h0000_00AA, 32'd0, 1'b0);
        do_op("pre_mtlo", MD_MTLO, 32'h0000_00BB, 32'd0, 1'b0);
        Start = 1'b1; MDOp = MD_MULT; A = 32'd7; B = 32'd6;
        @(negedge clk);
        Start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("midrst_busy", 64'(Busy), 64'd0);
        check_val("midrst_hi", HI, 32'd0);
        check_val("midrst_lo", LO, 32'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check_val("midrst_nocommit_busy", 64'(Busy), 64'd0);
        check_val("midrst_nocommit_hi", HI, 32'd0);
        check_val("midrst_nocommit_lo", LO, 32'd0);

        do_op("mult_neg", MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check_val("mult_neg_hi_const", HI, 32'hFFFF_FFFF);
        check_val("mult_neg_lo_const", LO, 32'hFFFF_FFFA);
        do_op("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check_val("multu_hi_const", HI, 32'h0000_0002);
        do_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check_val("div_neg_lo_const", LO, 32'hFFFF_FFFD);
        check_val("div_neg_hi_const", HI, 32'hFFFF_FFFF);
        do_op("divu", MD_DIVU, 32'd7, 32'd2, 1'b0);
        do_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check_val("div_ovf_lo_const", LO, 32'h8000_0000);
        check_val("div_ovf_hi_const", HI, 32'h0000_0000);

        do_op("set_hi", MD_MTHI, 32'h11, 32'd0, 1'b0);
        do_op("set_lo", MD_MTLO, 32'h22, 32'd0, 1'b0);
        do_op("div0", MD_DIV, 32'd5, 32'd0, 1'b0);
        check_val("div0_hi_const", HI, 32'h11);
        check_val("div0_lo_const", LO, 32'h22);
        do_op("divu0", MD_DIVU, 32'd9, 32'd0, 1'b0);

        do_op("mthi", MD_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
        do_op("none", MD_NONE, 32'h1234_5678, 32'd9, 1'b0);
        do_op("rsvd", MD_RSVD, 32'h1234_5678, 32'd9, 1'b0);
        do_op("mult_poke", MD_MULT, 32'd1000, 32'd77, 1'b1);
        do_op("b2b_mult", MD_MULT, 32'hFFFF_0000, 32'h0001_0001, 1'b0);
        do_op("b2b_divu", MD_DIVU, 32'hFFFF_FFFF, 32'd10, 1'b1);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            do_op("rand", rop, ra, rb, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
